// File: rtl/gpio_bus_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpio_bus_controller                                          |
// | Description : Sequences CPU I/O-space accesses (write/read/SBI/CBI) onto   |
// |               the per-port DDR/PORT/PIN register banks. Optional macro     |
// |               GPIO_PIN_TOGGLE_EN enables PINx-write toggling of PORTx.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpio_bus_controller #(
    parameter int         NUM_PORTS = 4,
    parameter int         WIDTH     = 8,
    parameter logic [5:0] BASE_ADDR = 6'h10
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [5:0]                 io_addr,
    input  logic                       io_wr,
    input  logic                       io_rd,
    input  logic                       io_sbi,
    input  logic                       io_cbi,
    input  logic [2:0]                 io_bit,
    input  logic [WIDTH-1:0]           io_wdata,
    input  logic [NUM_PORTS*WIDTH-1:0] ddr_q,
    input  logic [NUM_PORTS*WIDTH-1:0] port_q,
    input  logic [NUM_PORTS*WIDTH-1:0] pin_q,
    output logic [NUM_PORTS-1:0]       ddr_we,
    output logic [NUM_PORTS-1:0]       port_we,
    output logic [WIDTH-1:0]           reg_wdata,
    output logic [WIDTH-1:0]           io_rdata,
    output logic                       io_rvalid,
    output logic                       ready,
    output logic                       addr_err
);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_WRITE     = 3'd1;
    localparam logic [2:0] c_S_READ      = 3'd2;
    localparam logic [2:0] c_S_RMW_MOD   = 3'd3;
    localparam logic [2:0] c_S_RMW_WRITE = 3'd4;

    localparam logic [1:0] c_OP_SET   = 2'd0;
    localparam logic [1:0] c_OP_CLR   = 2'd1;
    localparam logic [1:0] c_OP_TBIT  = 2'd2;
    localparam logic [1:0] c_OP_TMASK = 2'd3;

`ifdef GPIO_PIN_TOGGLE_EN
    localparam logic c_TOGGLE_EN = 1'b1;
`else
    localparam logic c_TOGGLE_EN = 1'b0;
`endif

    logic [2:0]           r_state;
    logic [NUM_PORTS-1:0] r_sel;
    logic                 r_is_ddr;
    logic [1:0]           r_op;
    logic [2:0]           r_bit;
    logic [WIDTH-1:0]     r_wdata;
    logic                 r_kill;

    logic [NUM_PORTS-1:0] w_pin_sel;
    logic [NUM_PORTS-1:0] w_ddr_sel;
    logic [NUM_PORTS-1:0] w_port_sel;
    logic                 w_pin_hit;
    logic                 w_reg_hit;
    logic                 w_bit_range;
    logic [WIDTH-1:0]     w_rd_val;
    logic [WIDTH-1:0]     w_rmw_cur;
    logic [WIDTH-1:0]     w_rmw_val;
    logic [WIDTH-1:0]     w_bit_mask;

    // Port p sits r = NUM_PORTS-1-p register triplets above BASE_ADDR.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        localparam logic [5:0] c_PIN_ADDR = 6'(int'(BASE_ADDR) + 3 * (NUM_PORTS - 1 - p));
        assign w_pin_sel[p]  = (io_addr == c_PIN_ADDR);
        assign w_ddr_sel[p]  = (io_addr == c_PIN_ADDR + 6'd1);
        assign w_port_sel[p] = (io_addr == c_PIN_ADDR + 6'd2);
    end

    assign w_pin_hit   = |w_pin_sel;
    assign w_reg_hit   = |(w_ddr_sel | w_port_sel);
    assign w_bit_range = ~io_addr[5];
    assign ready       = (r_state == c_S_IDLE);
    assign w_bit_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << r_bit;

    // Decode is one-hot, so OR-reducing the selected slices acts as a mux.
    always_comb begin
        w_rd_val  = '0;
        w_rmw_cur = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pin_sel[p])  w_rd_val = w_rd_val | pin_q[p*WIDTH +: WIDTH];
            if (w_ddr_sel[p])  w_rd_val = w_rd_val | ddr_q[p*WIDTH +: WIDTH];
            if (w_port_sel[p]) w_rd_val = w_rd_val | port_q[p*WIDTH +: WIDTH];
            if (r_sel[p])
                w_rmw_cur = w_rmw_cur | (r_is_ddr ? ddr_q[p*WIDTH +: WIDTH]
                                                  : port_q[p*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        w_rmw_val = w_rmw_cur;
        case (r_op)
            c_OP_SET:   w_rmw_val = w_rmw_cur | w_bit_mask;
            c_OP_CLR:   w_rmw_val = w_rmw_cur & ~w_bit_mask;
            c_OP_TBIT:  w_rmw_val = w_rmw_cur ^ w_bit_mask;
            c_OP_TMASK: w_rmw_val = w_rmw_cur ^ r_wdata;
            default:    w_rmw_val = w_rmw_cur;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= c_S_IDLE;
            r_sel     <= '0;
            r_is_ddr  <= 1'b0;
            r_op      <= c_OP_SET;
            r_bit     <= '0;
            r_wdata   <= '0;
            r_kill    <= 1'b0;
            ddr_we    <= '0;
            port_we   <= '0;
            reg_wdata <= '0;
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            ddr_we    <= '0;
            port_we   <= '0;
            io_rvalid <= 1'b0;
            addr_err  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_bit   <= io_bit;
                    r_wdata <= io_wdata;
                    if (io_wr) begin
                        if (w_reg_hit) begin
                            r_state   <= c_S_WRITE;
                            reg_wdata <= io_wdata;
                            ddr_we    <= w_ddr_sel;
                            port_we   <= w_port_sel;
                        end else if (w_pin_hit && c_TOGGLE_EN) begin
                            r_state  <= c_S_RMW_MOD;
                            r_sel    <= w_pin_sel;
                            r_is_ddr <= 1'b0;
                            r_op     <= c_OP_TMASK;
                            r_kill   <= 1'b0;
                        end else begin
                            r_state  <= c_S_WRITE;
                            addr_err <= 1'b1;
                        end
                    end else if (io_sbi || io_cbi) begin
                        r_state  <= c_S_RMW_MOD;
                        r_sel    <= w_ddr_sel | w_port_sel;
                        r_is_ddr <= |w_ddr_sel;
                        r_op     <= io_sbi ? c_OP_SET : c_OP_CLR;
                        r_kill   <= 1'b0;
                        if (w_bit_range && w_reg_hit) begin
                            r_kill <= 1'b0;
                        end else if (w_bit_range && w_pin_hit && c_TOGGLE_EN) begin
                            // SBI toggles the PORT bit; CBI on PIN is a silent no-op.
                            r_sel    <= w_pin_sel;
                            r_is_ddr <= 1'b0;
                            r_op     <= c_OP_TBIT;
                            r_kill   <= ~io_sbi;
                        end else begin
                            r_kill   <= 1'b1;
                            addr_err <= 1'b1;
                        end
                    end else if (io_rd) begin
                        r_state   <= c_S_READ;
                        io_rdata  <= w_rd_val;
                        io_rvalid <= 1'b1;
                        addr_err  <= ~(w_reg_hit | w_pin_hit);
                    end
                end
                c_S_RMW_MOD: begin
                    r_state   <= c_S_RMW_WRITE;
                    reg_wdata <= w_rmw_val;
                    if (!r_kill) begin
                        ddr_we  <= r_is_ddr ? r_sel : '0;
                        port_we <= r_is_ddr ? '0 : r_sel;
                    end
                end
                c_S_WRITE, c_S_READ, c_S_RMW_WRITE: r_state <= c_S_IDLE;
                default:                             r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
